// File: rtl/sipo_pkg.sv
// Shared definitions for the serial link receive path: FSM state encoding
// and the default word width.
package sipo_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int unsigned WIDTH_DEFAULT = 4;

endpackage

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: assembles WIDTH serial bits into a word,
// presents it on a valid/ready output, realigns on sync and flags overruns.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEFAULT,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_in,
    input  logic                     s_en,
    input  logic                     sync,
    output logic [WIDTH-1:0]         p_data,
    output logic                     p_valid,
    input  logic                     p_ready,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overrun
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d, sh_shift;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] pdata_q, pdata_d;
    logic             pvalid_q, pvalid_d;
    logic             ovr_q, ovr_d;

    always_comb begin
        if (LSB_FIRST) begin
            sh_shift = {s_in, sh_q[WIDTH-1:1]};
        end else begin
            sh_shift = {sh_q[WIDTH-2:0], s_in};
        end
    end

    always_comb begin
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        pdata_d  = pdata_q;
        pvalid_d = pvalid_q & ~p_ready;
        ovr_d    = 1'b0;
        if (sync) begin
            // Realignment: the shift register contents need no clearing, only
            // the count decides where the word boundary falls.
            if (s_en) begin
                sh_d    = sh_shift;
                cnt_d   = CW'(1);
                state_d = ST_SHIFT;
            end else begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        end else if (s_en) begin
            sh_d = sh_shift;
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                state_d = ST_IDLE;
                if (pvalid_q && !p_ready) begin
                    ovr_d = 1'b1;
                end else begin
                    pdata_d  = sh_shift;
                    pvalid_d = 1'b1;
                end
            end else begin
                cnt_d   = cnt_q + CW'(1);
                state_d = ST_SHIFT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sh_q     <= '0;
            cnt_q    <= '0;
            pdata_q  <= '0;
            pvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            pdata_q  <= pdata_d;
            pvalid_q <= pvalid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign p_data  = pdata_q;
    assign p_valid = pvalid_q;
    assign busy    = (state_q == ST_SHIFT);
    assign bit_cnt = cnt_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: one LSB-first and one MSB-first instance, WIDTH=4.
module tb_sipo_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_in, s_en, sync, p_ready;
    logic [3:0] p_data;
    logic       p_valid, busy, overrun;
    logic [1:0] bit_cnt;

    logic       s_in2, s_en2, sync2, p_ready2;
    logic [3:0] p_data2;
    logic       p_valid2, busy2, overrun2;
    logic [1:0] bit_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .s_in(s_in), .s_en(s_en), .sync(sync),
        .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready),
        .busy(busy), .bit_cnt(bit_cnt), .overrun(overrun)
    );

    sipo_rx #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .s_in(s_in2), .s_en(s_en2), .sync(sync2),
        .p_data(p_data2), .p_valid(p_valid2), .p_ready(p_ready2),
        .busy(busy2), .bit_cnt(bit_cnt2), .overrun(overrun2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        s_in = b;
        s_en = 1'b1;
        tick();
        s_en = 1'b0;
    endtask

    task automatic send2(input logic b);
        s_in2 = b;
        s_en2 = 1'b1;
        tick();
        s_en2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_in = 1'b0; s_en = 1'b0; sync = 1'b0; p_ready = 1'b0;
        s_in2 = 1'b0; s_en2 = 1'b0; sync2 = 1'b0; p_ready2 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_pdata", p_data, 4'h0);
        chk("rst_pvalid", p_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", bit_cnt, 2'd0);
        chk("rst_ovr", overrun, 1'b0);

        // 1: bits 0,1,0,1 -> 1010, held under backpressure
        send(1'b0); send(1'b1);
        chk("t1_cnt2", bit_cnt, 2'd2);
        chk("t1_busy", busy, 1'b1);
        send(1'b0);
        chk("t1_pvalid_early", p_valid, 1'b0);
        send(1'b1);
        chk("t1_pdata", p_data, 4'b1010);
        chk("t1_pvalid", p_valid, 1'b1);
        chk("t1_cnt_wrap", bit_cnt, 2'd0);
        chk("t1_idle", busy, 1'b0);
        tick();
        chk("t1_hold_valid", p_valid, 1'b1);
        chk("t1_hold_data", p_data, 4'b1010);
        p_ready = 1'b1; tick(); p_ready = 1'b0;
        chk("t1_consumed", p_valid, 1'b0);

        // 2: back-to-back 1111 then 0000 with p_ready=1
        p_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(i < 4);
            chk("t2_ovr", overrun, 1'b0);
            if (i == 3) begin
                chk("t2_w1_data", p_data, 4'b1111);
                chk("t2_w1_valid", p_valid, 1'b1);
            end
            if (i == 4) chk("t2_w1_taken", p_valid, 1'b0);
        end
        chk("t2_w2_data", p_data, 4'b0000);
        chk("t2_w2_valid", p_valid, 1'b1);
        tick();
        chk("t2_w2_taken", p_valid, 1'b0);
        p_ready = 1'b0;

        // 3: 1100 held, 0011 completes -> dropped with overrun pulse
        send(1'b0); send(1'b0); send(1'b1); send(1'b1);
        chk("t3_w1_data", p_data, 4'b1100);
        send(1'b1); send(1'b1); send(1'b0);
        chk("t3_no_ovr_yet", overrun, 1'b0);
        send(1'b0);
        chk("t3_ovr", overrun, 1'b1);
        chk("t3_kept_data", p_data, 4'b1100);
        chk("t3_kept_valid", p_valid, 1'b1);
        tick();
        chk("t3_ovr_pulse", overrun, 1'b0);
        p_ready = 1'b1; tick(); p_ready = 1'b0;
        chk("t3_consumed", p_valid, 1'b0);

        // 4: two bits, then sync&s_en (1), then 0,1,1 -> 1101
        send(1'b1); send(1'b1);
        sync = 1'b1; send(1'b1); sync = 1'b0;
        chk("t4_sync_cnt", bit_cnt, 2'd1);
        chk("t4_sync_busy", busy, 1'b1);
        send(1'b0); send(1'b1);
        chk("t4_no_early", p_valid, 1'b0);
        send(1'b1);
        chk("t4_pdata", p_data, 4'b1101);
        chk("t4_pvalid", p_valid, 1'b1);
        p_ready = 1'b1; send(1'b0); p_ready = 1'b0;
        chk("t4_partial_cnt", bit_cnt, 2'd1);
        sync = 1'b1; tick(); sync = 1'b0;
        chk("t4_sync_only_cnt", bit_cnt, 2'd0);
        chk("t4_sync_only_busy", busy, 1'b0);

        // 5: reset mid-word with a word pending, then 0101
        send(1'b1); send(1'b0); send(1'b1); send(1'b0);
        chk("t5_pending", p_valid, 1'b1);
        send(1'b0); send(1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t5_rst_pdata", p_data, 4'h0);
        chk("t5_rst_pvalid", p_valid, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_cnt", bit_cnt, 2'd0);
        chk("t5_rst_ovr", overrun, 1'b0);
        send(1'b1); send(1'b0); send(1'b1); send(1'b0);
        chk("t5_pdata", p_data, 4'b0101);
        chk("t5_pvalid", p_valid, 1'b1);

        // 6: MSB-first, contiguous then gapped 1,1,0,0 -> 1100
        send2(1'b1); send2(1'b1); send2(1'b0); send2(1'b0);
        chk("t6_pdata", p_data2, 4'b1100);
        chk("t6_pvalid", p_valid2, 1'b1);
        p_ready2 = 1'b1; tick(); p_ready2 = 1'b0;
        chk("t6_consumed", p_valid2, 1'b0);
        send2(1'b1); tick();
        chk("t6_gap1_busy", busy2, 1'b1);
        send2(1'b1); tick(); tick();
        chk("t6_gap2_busy", busy2, 1'b1);
        chk("t6_gap2_cnt", bit_cnt2, 2'd2);
        send2(1'b0); tick();
        chk("t6_gap3_busy", busy2, 1'b1);
        send2(1'b0);
        chk("t6_gap_pdata", p_data2, 4'b1100);
        chk("t6_gap_pvalid", p_valid2, 1'b1);
        chk("t6_gap_idle", busy2, 1'b0);
        chk("t6_ovr", overrun2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
